// File: rtl/ctrl_unit.sv
// Sequencer for a 16-bit accumulator machine: fetches from synchronous RAM,
// decodes the opcode and drives the datapath load/select strobes.
module ctrl_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic [15:0] mem_rdata,
  input  logic        carry,
  output logic [11:0] mem_addr,
  output logic        mem_en,
  output logic        mem_we,
  output logic [2:0]  sel_UAL,
  output logic        load_R1,
  output logic        load_accu,
  output logic        load_carry,
  output logic        init_carry,
  output logic        halted,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_OPREAD = 3'd2,
    S_LOADR1 = 3'd3,
    S_EXEC   = 3'd4,
    S_STORE  = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_STA = 4'h7;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_JCC = 4'h9;
  localparam logic [3:0] OP_HLT = 4'hA;

  state_t      state, state_next;
  logic [11:0] pc, pc_next;
  logic [15:0] ir, ir_next;

  logic [11:0] addr_raw;
  logic [2:0]  sel_raw;
  logic        en_raw, we_raw, r1_raw, acc_raw, lc_raw, ic_raw, halt_raw;

  wire [3:0] fetched_op = mem_rdata[15:12];
  wire [3:0] ir_op      = ir[15:12];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_FETCH;
      pc    <= 12'h000;
      ir    <= 16'h0000;
    end else if (ce) begin
      state <= state_next;
      pc    <= pc_next;
      ir    <= ir_next;
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    ir_next    = ir;
    case (state)
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        ir_next    = mem_rdata;
        pc_next    = pc + 12'd1;
        state_next = S_FETCH;
        case (fetched_op)
          OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: state_next = S_OPREAD;
          OP_STA: state_next = S_STORE;
          OP_HLT: state_next = S_HALT;
          OP_JMP: pc_next = mem_rdata[11:0];
          // A set carry skips the jump and consumes the flag instead.
          OP_JCC: if (!carry) pc_next = mem_rdata[11:0];
          default: state_next = S_FETCH;
        endcase
      end
      S_OPREAD: state_next = S_LOADR1;
      S_LOADR1: state_next = S_EXEC;
      S_EXEC:   state_next = S_FETCH;
      S_STORE:  state_next = S_FETCH;
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_FETCH;
    endcase
  end

  always_comb begin
    addr_raw = pc;
    sel_raw  = 3'b000;
    en_raw   = 1'b0;
    we_raw   = 1'b0;
    r1_raw   = 1'b0;
    acc_raw  = 1'b0;
    lc_raw   = 1'b0;
    ic_raw   = 1'b0;
    halt_raw = 1'b0;
    case (state)
      S_FETCH:  en_raw = 1'b1;
      S_DECODE: ic_raw = (fetched_op == OP_JCC) && carry;
      S_OPREAD: begin
        addr_raw = ir[11:0];
        en_raw   = 1'b1;
      end
      S_LOADR1: r1_raw = 1'b1;
      S_EXEC: begin
        acc_raw = 1'b1;
        lc_raw  = (ir_op == OP_ADD) || (ir_op == OP_SUB);
        case (ir_op)
          OP_ADD:  sel_raw = 3'b001;
          OP_SUB:  sel_raw = 3'b010;
          OP_AND:  sel_raw = 3'b011;
          OP_OR:   sel_raw = 3'b100;
          OP_XOR:  sel_raw = 3'b101;
          default: sel_raw = 3'b000;
        endcase
      end
      S_STORE: begin
        addr_raw = ir[11:0];
        en_raw   = 1'b1;
        we_raw   = 1'b1;
      end
      S_HALT:  halt_raw = 1'b1;
      default: ;
    endcase
  end

  // Reset blanks everything; a stalled cycle only silences the strobes.
  assign mem_addr   = rst ? addr_raw : 12'h000;
  assign sel_UAL    = rst ? sel_raw  : 3'b000;
  assign halted     = rst & halt_raw;
  assign mem_en     = rst & ce & en_raw;
  assign mem_we     = rst & ce & we_raw;
  assign load_R1    = rst & ce & r1_raw;
  assign load_accu  = rst & ce & acc_raw;
  assign load_carry = rst & ce & lc_raw;
  assign init_carry = rst & ce & ic_raw;
  assign state_dbg  = state;

endmodule

// File: tb/tb_ctrl_unit.sv
// Bench for ctrl_unit: directed scenarios plus a random program run checked
// against an instruction-level timing model of the sequencer.
module tb_ctrl_unit;

  logic        clk, rst, ce, carry;
  logic [15:0] mem_rdata;
  logic [11:0] mem_addr;
  logic        mem_en, mem_we, load_R1, load_accu, load_carry, init_carry, halted;
  logic [2:0]  sel_UAL, state_dbg;
  logic [21:0] obs;

  logic [15:0] mem [0:4095];
  logic [22:0] exp_q[$];   // {addr_valid, mem_addr, flags}
  int compared;
  int mismatched;

  // flags layout: en, we, sel[2:0], r1, accu, lc, ic, halted
  localparam logic [9:0] F_EN  = 10'h200;
  localparam logic [9:0] F_WE  = 10'h100;
  localparam logic [9:0] F_R1  = 10'h010;
  localparam logic [9:0] F_ACC = 10'h008;
  localparam logic [9:0] F_LC  = 10'h004;
  localparam logic [9:0] F_IC  = 10'h002;
  localparam logic [9:0] F_H   = 10'h001;
  localparam logic [9:0] STROBES = F_EN | F_WE | F_R1 | F_ACC | F_LC | F_IC;

  ctrl_unit dut (
    .clk(clk), .rst(rst), .ce(ce), .mem_rdata(mem_rdata), .carry(carry),
    .mem_addr(mem_addr), .mem_en(mem_en), .mem_we(mem_we), .sel_UAL(sel_UAL),
    .load_R1(load_R1), .load_accu(load_accu), .load_carry(load_carry),
    .init_carry(init_carry), .halted(halted), .state_dbg(state_dbg)
  );

  assign obs = {mem_addr, mem_en, mem_we, sel_UAL, load_R1, load_accu,
                load_carry, init_carry, halted};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM, one cycle read latency; write data is not modelled.
  always @(posedge clk) if (mem_en) mem_rdata <= mem[mem_addr];

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    ce  = 1'b1;
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic next_cycle(input logic ce_val);
    @(negedge clk);
    ce = ce_val;
    #1;
  endtask

  // Instruction-level model: expected per-cycle outputs for one instruction.
  task automatic model_instr(input logic [11:0] pc, input logic [15:0] w,
                             input logic c, output logic [11:0] npc);
    logic [3:0] op;
    logic [3:0] selw;
    logic [11:0] a;
    op   = w[15:12];
    a    = w[11:0];
    selw = op - 4'd1;
    npc  = pc + 12'd1;
    exp_q.push_back({1'b1, pc, F_EN});
    exp_q.push_back({1'b0, 12'h000, (op == 4'h9 && c) ? F_IC : 10'h000});
    if (op >= 4'h1 && op <= 4'h6) begin
      exp_q.push_back({1'b1, a, F_EN});
      exp_q.push_back({1'b0, 12'h000, F_R1});
      exp_q.push_back({1'b0, 12'h000, F_ACC | {2'b00, selw[2:0], 5'b00000} |
                       ((op == 4'h2 || op == 4'h3) ? F_LC : 10'h000)});
    end else if (op == 4'h7) begin
      exp_q.push_back({1'b1, a, F_EN | F_WE});
    end else if (op == 4'h8 || (op == 4'h9 && !c)) begin
      npc = a;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    ce  = 1'b0;
    #1;
    compared++;
    if (obs !== 22'h0) begin
      mismatched++;
      $display("FAIL reset_cycle obs=%h exp=%h", obs, 22'h0);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    next_cycle(1'b1);
    compared++;
    if (obs !== {12'h000, F_EN}) begin
      mismatched++;
      $display("FAIL reset_fetch obs=%h exp=%h", obs, {12'h000, F_EN});
    end
  endtask

  task automatic test_lda_add();
    logic [21:0] tab [10];
    logic [9:0]  care;
    mem[12'h000] = 16'h1010;
    mem[12'h010] = 16'h0005;
    mem[12'h001] = 16'h2011;
    mem[12'h011] = 16'h0003;
    carry = 1'b0;
    tab[0] = {12'h000, F_EN};  tab[1] = 22'h0;
    tab[2] = {12'h010, F_EN};  tab[3] = {12'h000, F_R1};
    tab[4] = {12'h000, F_ACC};
    tab[5] = {12'h001, F_EN};  tab[6] = 22'h0;
    tab[7] = {12'h011, F_EN};  tab[8] = {12'h000, F_R1};
    tab[9] = {12'h000, F_ACC | F_LC | 10'b0000100000};
    care = 10'b0010100101;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      next_cycle(1'b1);
      compared++;
      if (care[k] ? (obs !== tab[k]) : (obs[9:0] !== tab[k][9:0])) begin
        mismatched++;
        $display("FAIL lda_add cycle %0d obs=%h exp=%h", k, obs, tab[k]);
      end
    end
  endtask

  task automatic test_jmp();
    mem[12'h000] = 16'h8123;
    do_reset();
    next_cycle(1'b1);
    next_cycle(1'b1);
    next_cycle(1'b1);
    compared++;
    if (obs !== {12'h123, F_EN}) begin
      mismatched++;
      $display("FAIL jmp_target obs=%h exp=%h", obs, {12'h123, F_EN});
    end
  endtask

  task automatic test_jcc(input logic c);
    logic [21:0] tgt;
    mem[12'h000] = 16'h9040;
    carry = c;
    tgt = c ? {12'h001, F_EN} : {12'h040, F_EN};
    do_reset();
    next_cycle(1'b1);
    compared++;
    if (init_carry !== 1'b0) begin
      mismatched++;
      $display("FAIL jcc_ic_fetch c=%0b got=%b want=0", c, init_carry);
    end
    next_cycle(1'b1);
    compared++;
    if (obs[9:0] !== (c ? F_IC : 10'h000)) begin
      mismatched++;
      $display("FAIL jcc_decode c=%0b obs=%h exp_flags=%h", c, obs[9:0], c ? F_IC : 10'h000);
    end
    next_cycle(1'b1);
    compared++;
    if (obs !== tgt) begin
      mismatched++;
      $display("FAIL jcc_next c=%0b obs=%h exp=%h", c, obs, tgt);
    end
    carry = 1'b0;
  endtask

  task automatic test_sta();
    mem[12'h000] = 16'h7055;
    do_reset();
    next_cycle(1'b1);
    next_cycle(1'b1);
    next_cycle(1'b1);
    compared++;
    if (obs !== {12'h055, F_EN | F_WE}) begin
      mismatched++;
      $display("FAIL sta_store obs=%h exp=%h", obs, {12'h055, F_EN | F_WE});
    end
    next_cycle(1'b1);
    compared++;
    if (obs !== {12'h001, F_EN}) begin
      mismatched++;
      $display("FAIL sta_after obs=%h exp=%h", obs, {12'h001, F_EN});
    end
    // Reset landing on the STORE cycle must suppress the write.
    do_reset();
    next_cycle(1'b1);
    next_cycle(1'b1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    compared++;
    if (obs !== 22'h0) begin
      mismatched++;
      $display("FAIL sta_mid_reset obs=%h exp=%h", obs, 22'h0);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    next_cycle(1'b1);
    compared++;
    if (obs !== {12'h000, F_EN}) begin
      mismatched++;
      $display("FAIL sta_post_reset obs=%h exp=%h", obs, {12'h000, F_EN});
    end
  endtask

  task automatic test_halt();
    int bad;
    mem[12'h000] = 16'hA000;
    do_reset();
    next_cycle(1'b1);
    next_cycle(1'b1);
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      next_cycle($urandom_range(0, 3) != 0);
      compared++;
      if (obs[9:0] !== F_H) begin
        mismatched++;
        bad++;
        if (bad < 5) $display("FAIL halt_hold cycle %0d obs=%h exp_flags=%h", k, obs[9:0], F_H);
      end
    end
    $display("halt scenario done, state_dbg=%0d", state_dbg);
    @(negedge clk);
    rst = 1'b0;
    ce  = 1'b1;
    #1;
    compared++;
    if (obs !== 22'h0) begin
      mismatched++;
      $display("FAIL halt_reset obs=%h exp=%h", obs, 22'h0);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    next_cycle(1'b1);
    compared++;
    if (obs !== {12'h000, F_EN}) begin
      mismatched++;
      $display("FAIL halt_exit obs=%h exp=%h", obs, {12'h000, F_EN});
    end
  endtask

  task automatic test_stall();
    mem[12'h000] = 16'h1010;
    do_reset();
    next_cycle(1'b1);
    next_cycle(1'b1);
    next_cycle(1'b1);
    for (int k = 0; k < 3; k++) begin
      next_cycle(1'b0);
      compared++;
      if (obs[9:0] !== 10'h000) begin
        mismatched++;
        $display("FAIL stall_quiet cycle %0d obs=%h exp_flags=%h", k, obs[9:0], 10'h000);
      end
    end
    next_cycle(1'b1);
    compared++;
    if (obs[9:0] !== F_R1) begin
      mismatched++;
      $display("FAIL stall_resume obs=%h exp_flags=%h", obs[9:0], F_R1);
    end
    next_cycle(1'b1);
    compared++;
    if (obs[9:0] !== F_ACC) begin
      mismatched++;
      $display("FAIL stall_exec obs=%h exp_flags=%h", obs[9:0], F_ACC);
    end
  endtask

  task automatic test_wrap();
    mem[12'h000] = 16'h8FFF;
    mem[12'hFFF] = 16'h0000;
    do_reset();
    next_cycle(1'b1);
    next_cycle(1'b1);
    next_cycle(1'b1);
    compared++;
    if (obs !== {12'hFFF, F_EN}) begin
      mismatched++;
      $display("FAIL wrap_fetch_fff obs=%h exp=%h", obs, {12'hFFF, F_EN});
    end
    next_cycle(1'b1);
    next_cycle(1'b1);
    compared++;
    if (obs !== {12'h000, F_EN}) begin
      mismatched++;
      $display("FAIL wrap_fetch_000 obs=%h exp=%h", obs, {12'h000, F_EN});
    end
  endtask

  task automatic test_random();
    logic [11:0] pc, npc;
    logic [3:0]  op;
    logic        c;
    logic [22:0] e;
    logic [21:0] ev;
    int bad;
    for (int a = 0; a < 4096; a++) begin
      op = 4'($urandom_range(0, 15));
      if (op == 4'hA) op = 4'h0;
      mem[a] = {op, 12'($urandom)};
    end
    exp_q.delete();
    do_reset();
    pc  = 12'h000;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      c = 1'($urandom_range(0, 1));
      model_instr(pc, mem[pc], c, npc);
      while (exp_q.size() > 0) begin
        @(negedge clk);
        carry = c;
        ce    = ($urandom_range(0, 3) != 0);
        #1;
        e  = exp_q[0];
        ev = ce ? e[21:0] : (e[21:0] & ~{12'h000, STROBES});
        compared++;
        if (e[22] ? (obs !== ev) : (obs[9:0] !== ev[9:0])) begin
          mismatched++;
          bad++;
          if (bad < 10) $display("FAIL random instr %0d pc=%h obs=%h exp=%h", i, pc, obs, ev);
        end
        if (ce) void'(exp_q.pop_front());
      end
      pc = npc;
    end
    carry = 1'b0;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst   = 1'b0;
    ce    = 1'b0;
    carry = 1'b0;
    for (int a = 0; a < 4096; a++) mem[a] = 16'h0000;
    test_reset();
    test_lda_add();
    test_jmp();
    test_jcc(1'b0);
    test_jcc(1'b1);
    test_sta();
    test_halt();
    test_stall();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ctrl_unit.md
CTRL_UNIT -- requirements
Module: ctrl_unit

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset: clk samples everything; rst low at a rising clk edge resets the block.
REQ-002 clk  in  1  system clock, rising edge active.
REQ-003 rst  in  1  synchronous active-low reset.
REQ-004 ce  in  1  clock enable; when low the block holds all state.
REQ-005 mem_rdata  in  16  memory read data (synchronous RAM, 1-cycle latency).
REQ-006 carry  in  1  registered carry flag from the datapath.
REQ-007 mem_addr  out  12  memory address.
REQ-008 mem_en  out  1  memory access strobe.
REQ-009 mem_we  out  1  memory write strobe; write data is the datapath accumulator output.
REQ-010 sel_UAL  out  3  ALU operation select.
REQ-011 load_R1  out  1  R1 loads from the memory data bus.
REQ-012 load_accu  out  1  accumulator loads the ALU result.
REQ-013 load_carry  out  1  carry register loads the ALU carry.
REQ-014 init_carry  out  1  carry register clears.
REQ-015 halted  out  1  high while in HALT.

Function
REQ-016 Instruction word: opcode = mem_rdata[15:12]; address = mem_rdata[11:0].
REQ-017 Opcodes:
- 0 NOP
- 1 LDA (sel 000, pass R1)
- 2 ADD (sel 001)
- 3 SUB (sel 010)
- 4 AND (sel 011)
- 5 OR (sel 100)
- 6 XOR (sel 101)
- 7 STA
- 8 JMP
- 9 JCC
- A HLT
- B-F behave as NOP.
REQ-018 Internal registers: PC (12 b), IR (16 b), state.
REQ-019 FSM states: FETCH, DECODE, OPREAD, LOADR1, EXEC, STORE, HALT.
REQ-020 FETCH: mem_addr=PC, mem_en=1; next state is DECODE.
REQ-021 DECODE actions:
- IR <= mem_rdata.
- PC <= PC+1, wrapping 0xFFF->0x000, except for the jump cases below.
- Next state: opcodes 1-6 -> OPREAD; 7 -> STORE; A -> HALT; all others -> FETCH.
REQ-022 JMP in DECODE: PC <= mem_rdata[11:0].
REQ-023 JCC in DECODE when carry=0: PC <= mem_rdata[11:0].
REQ-024 JCC in DECODE when carry=1: PC <= PC+1 and init_carry=1 for that cycle.
REQ-025 OPREAD: mem_addr=IR[11:0], mem_en=1; next state is LOADR1.
REQ-026 LOADR1: load_R1=1; next state is EXEC.
REQ-027 EXEC: sel_UAL per the opcode table; load_accu=1; next state is FETCH.
REQ-028 EXEC for ADD and SUB only: load_carry=1.
REQ-029 STORE: mem_addr=IR[11:0], mem_en=1, mem_we=1; next state is FETCH.
REQ-030 HALT: halted=1, all strobes 0; exit only via reset.
REQ-031 Latency in ce=1 cycles:
- NOP, JMP, JCC, undefined opcodes: 2 cycles.
- STA: 3 cycles.
- LDA and ALU ops: 5 cycles.
REQ-032 Outputs are combinational decodes of state and IR, except the JCC init_carry, which decodes mem_rdata in DECODE.
REQ-033 ce=0 handling:
- state, PC and IR hold.
- mem_en, mem_we, load_R1, load_accu, load_carry and init_carry are forced to 0.
- mem_addr, sel_UAL and halted keep their values.
REQ-034 sel_UAL is 000 in every state other than EXEC.
REQ-035 mem_we is never high unless mem_en is high.
REQ-036 load_carry and init_carry are never high in the same cycle.

Reset
REQ-037 rst=0 at an edge SHALL set state=FETCH, PC=0x000, IR=0x0000, regardless of ce.
REQ-038 The reset values of outputs 1-6 below are forced low during the reset cycle; from the cycle after reset, outputs follow the FETCH decode:
1. mem_addr=0x000
2. mem_en=1
3. mem_we=0
4. sel_UAL=000
5. load strobes=0
6. halted=0
REQ-039 Reset SHALL take effect mid-instruction, from any state including HALT, with no write strobe issued after the reset edge.

Verification
REQ-040 Sequence after reset with mem[0]=0x1010, mem[0x010]=0x0005, mem[1]=0x2011 (ADD) -> required response:
- Cycles 0-4: mem_addr 000,010 then load_R1, then load_accu with sel 000.
- Cycles 5-9: load_R1, then load_accu+load_carry with sel 001.
REQ-041 mem[0]=0x8123 -> required response: the next FETCH drives mem_addr=0x123, 2 cycles after reset release.
REQ-042 JCC 0x9040:
- carry=0 -> PC=0x040.
- carry=1 -> PC=0x001, init_carry pulses for exactly 1 cycle.
REQ-043 STA 0x7055 -> required response: the cycle-2 STORE drives mem_addr=0x055 with mem_en=1 and mem_we=1 for 1 cycle.
REQ-044 HLT 0xA000 -> required response: halted=1 within 2 cycles and stays high for 100 cycles; rst=0 returns mem_addr to 0x000.
REQ-045 ce=0 held for 3 cycles during LOADR1 -> required response: no strobes during the stall; load_R1 is issued once ce returns.
REQ-046 PC=0xFFF with NOP -> required response: the next fetch is at 0x000.
